// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types, default widths and round-robin pick helper for
//               the APB master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    localparam int c_def_num_req = 4;
    localparam int c_def_addr_w  = 32;
    localparam int c_def_data_w  = 32;
    localparam int c_def_timeout = 16;
    localparam int c_max_req     = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    // First set bit of mask at or after ptr, wrapping. Unused upper mask bits
    // must be zero so the 8-wide wrap matches a NUM_REQ-wide wrap.
    function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                           input logic [7:0] mask);
        logic [2:0] w_idx;
        logic [2:0] w_win;
        logic       w_found;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < c_max_req; i++) begin
            w_idx = ptr + 3'(i);
            if (!w_found && mask[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        return w_win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Round-robin grant selection with a pointer that advances past
//               each granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_def_num_req
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_eligible,
    input  logic                       i_grant_en,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_valid
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);

    logic [c_idx_w-1:0] r_ptr;
    logic [7:0]         w_mask;
    logic [2:0]         w_win;

    always_comb begin
        w_mask              = '0;
        w_mask[NUM_REQ-1:0] = i_eligible;
    end

    assign w_win   = next_rr(3'(r_ptr), w_mask);
    assign o_grant = c_idx_w'(w_win);
    assign o_valid = |i_eligible;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_grant_en) begin
            r_ptr <= (o_grant == c_last_idx) ? '0 : o_grant + c_idx_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Shares one APB4 master port between NUM_REQ requesters with
//               round-robin arbitration and a wait-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = c_def_num_req,
    parameter int ADDR_W  = c_def_addr_w,
    parameter int DATA_W  = c_def_data_w,
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]          write_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    input  logic [NUM_REQ*DATA_W/8-1:0] strb_i,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        err_o,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_W-1:0]           paddr,
    output logic [DATA_W-1:0]           pwdata,
    output logic [DATA_W/8-1:0]         pstrb,
    input  logic                        pready,
    input  logic                        pslverr,
    input  logic [DATA_W-1:0]           prdata
);

    localparam int c_idx_w  = $clog2(NUM_REQ);
    localparam int c_strb_w = DATA_W / 8;
    localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t           r_state;
    apb_state_t           w_next_state;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_cnt_w-1:0]   r_wait;
    logic [NUM_REQ-1:0]   r_done;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;
    logic                 r_pwrite;
    logic [ADDR_W-1:0]    r_paddr;
    logic [DATA_W-1:0]    r_pwdata;
    logic [c_strb_w-1:0]  r_pstrb;
    logic [NUM_REQ-1:0]   w_eligible;
    logic [c_idx_w-1:0]   w_grant;
    logic                 w_valid;
    logic                 w_grant_en;
    logic                 w_timeout;
    logic                 w_complete;

    // The requester just being told it is done may not win the same cycle.
    assign w_eligible = req_i & ~r_done;
    assign w_grant_en = (r_state == ST_IDLE) && w_valid;
    assign w_timeout  = (TIMEOUT != 0) && !pready && (r_wait == c_wait_last);
    assign w_complete = (r_state == ST_ACCESS) && (pready || w_timeout);

    apb_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr (
        .clk        (pclk),
        .rst        (preset),
        .i_eligible (w_eligible),
        .i_grant_en (w_grant_en),
        .o_grant    (w_grant),
        .o_valid    (w_valid)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next_state = ST_SETUP;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_complete) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // psel/penable decode straight from state so reset drops them at once.
    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        case (r_state)
            ST_SETUP:  psel = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_owner  <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_grant_en) begin
            r_owner  <= w_grant;
            r_pwrite <= write_i[w_grant];
            r_paddr  <= addr_i[int'(w_grant)*ADDR_W +: ADDR_W];
            r_pwdata <= wdata_i[int'(w_grant)*DATA_W +: DATA_W];
            r_pstrb  <= write_i[w_grant] ? strb_i[int'(w_grant)*c_strb_w +: c_strb_w] : '0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait <= '0;
        end else if ((r_state == ST_ACCESS) && !pready) begin
            r_wait <= r_wait + c_cnt_w'(1);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_complete) begin
                r_done[r_owner] <= 1'b1;
                r_err           <= pready ? pslverr : 1'b1;
                r_rdata         <= (pready && !r_pwrite) ? prdata : '0;
            end
        end
    end

    assign done_o  = r_done;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
    assign pstrb   = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Directed and randomized bench with a round-robin reference
//               model and a scripted APB slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic              pclk    = 1'b0;
    logic              preset  = 1'b1;
    logic [N-1:0]      req_i   = '0;
    logic [N*AW-1:0]   addr_i  = '0;
    logic [N-1:0]      write_i = '0;
    logic [N*DW-1:0]   wdata_i = '0;
    logic [N*SW-1:0]   strb_i  = '0;
    logic              pready  = 1'b0;
    logic              pslverr = 1'b0;
    logic [DW-1:0]     prdata  = '0;
    logic [N-1:0]      done_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;

    apb_master_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .write_i (write_i),
        .wdata_i (wdata_i),
        .strb_i  (strb_i),
        .done_o  (done_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .pslverr (pslverr),
        .prdata  (prdata)
    );

    always #5 pclk = ~pclk;

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;

    logic [AW-1:0] m_addr  [N];
    logic          m_wr    [N];
    logic [DW-1:0] m_wdata [N];
    logic [SW-1:0] m_strb  [N];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference round-robin: first eligible index scanning upward from the
    // pointer modulo N; the pointer then moves one past the winner.
    function automatic int pick(input logic [N-1:0] elig);
        int win = -1;
        for (int i = 0; i < N; i++) begin
            if (win < 0 && elig[(m_ptr + i) % N]) win = (m_ptr + i) % N;
        end
        if (win >= 0) m_ptr = (win + 1) % N;
        return win;
    endfunction

    task automatic new_cmd(input int i);
        m_addr[i]  = ($urandom & 32'hFFFF_FFF0) | 32'(i);
        m_wr[i]    = 1'($urandom_range(0, 1));
        m_wdata[i] = $urandom;
        m_strb[i]  = 4'($urandom_range(1, 15));
    endtask

    task automatic drive(input logic [N-1:0] pend);
        for (int i = 0; i < N; i++) begin
            req_i[i]              = pend[i];
            write_i[i]            = m_wr[i];
            addr_i[i*AW +: AW]    = m_addr[i];
            wdata_i[i*DW +: DW]   = m_wdata[i];
            strb_i[i*SW +: SW]    = m_strb[i];
        end
    endtask

    // Called in the expected SETUP cycle; returns in the expected done cycle.
    task automatic xfer(input int own, input int waits, input bit tmo,
                        input logic [DW-1:0] rd, input bit slverr);
        logic [SW-1:0] exp_strb;
        int cnt;
        exp_strb = m_wr[own] ? m_strb[own] : '0;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_done_clear", done_o, 0);
        chk("setup_paddr", paddr, m_addr[own]);
        chk("setup_pwrite", pwrite, m_wr[own]);
        chk("setup_pstrb", pstrb, exp_strb);
        if (m_wr[own]) chk("setup_pwdata", pwdata, m_wdata[own]);
        tick();
        cnt = 0;
        for (int guard = 0; guard <= TMO; guard++) begin
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, m_addr[own]);
            chk("access_pstrb", pstrb, exp_strb);
            if (!tmo && cnt == waits) begin
                pready  = 1'b1;
                prdata  = rd;
                pslverr = slverr;
                tick();
                break;
            end
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
            tick();
            cnt++;
            if (tmo && cnt == TMO) break;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("done_mask", done_o, 64'(1 << own));
        chk("done_err", err_o, tmo ? 1'b1 : slverr);
        chk("done_rdata", rdata_o, (tmo || m_wr[own]) ? '0 : rd);
        chk("done_psel", psel, 0);
    endtask

    initial begin
        logic [N-1:0] pend;
        logic [N-1:0] elig;
        logic [N-1:0] ldm;
        int w, nx;
        int order [5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0; m_wr[i] = 1'b0; m_wdata[i] = '0; m_strb[i] = '0;
        end

        // Reset values
        tick(); tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        preset = 1'b0;
        m_ptr  = 0;
        tick();

        // Requester 0 zero-wait write
        m_addr[0] = 32'h10; m_wr[0] = 1'b1; m_wdata[0] = 32'hA5A5_0001; m_strb[0] = 4'hF;
        pend = 4'b0001; drive(pend);
        tick(); w = pick(pend);
        xfer(w, 0, 0, '0, 0);
        pend = '0; drive(pend);
        tick();

        // Requester 2 read with 3 wait states
        m_addr[2] = 32'h20; m_wr[2] = 1'b0; m_strb[2] = 4'hF;
        pend = 4'b0100; drive(pend);
        tick(); w = pick(pend);
        xfer(w, 3, 0, 32'hDEAD_BEEF, 0);
        pend = '0; drive(pend);
        tick();

        // All four from pointer 0, each re-issuing in its done cycle
        preset = 1'b1; tick(); preset = 1'b0; m_ptr = 0;
        for (int i = 0; i < N; i++) new_cmd(i);
        pend = 4'b1111; drive(pend);
        for (int s = 0; s < 5; s++) begin
            tick();
            w = order[s];
            m_ptr = (w + 1) % N;
            xfer(w, $urandom_range(0, 2), 0, $urandom, 0);
            if (s < 4) new_cmd(w); else pend = '0;
            drive(pend);
        end
        tick();

        // Slave error on a write from requester 1
        new_cmd(1); m_wr[1] = 1'b1;
        pend = 4'b0010; drive(pend);
        tick(); w = pick(pend);
        xfer(w, 1, 0, '0, 1);
        pend = '0; drive(pend);
        tick();

        // Timeout on requester 3, then requester 0 with pready on the last allowed cycle
        new_cmd(3); m_wr[3] = 1'b0; new_cmd(0);
        pend = 4'b1001; drive(pend);
        tick(); w = pick(pend);
        xfer(w, 0, 1, '0, 0);
        pend[w] = 1'b0; drive(pend);
        tick(); w = pick(pend);
        xfer(w, TMO - 1, 0, $urandom, 0);
        pend = '0; drive(pend);
        tick();

        // Reset during ACCESS
        new_cmd(1);
        pend = 4'b0010; drive(pend);
        tick(); chk("prerst_psel", psel, 1);
        tick(); chk("prerst_penable", penable, 1);
        preset = 1'b1;
        #1;
        chk("async_rst_psel", psel, 0);
        chk("async_rst_penable", penable, 0);
        tick();
        chk("rst_no_done", done_o, 0);
        pend = '0; drive(pend);
        preset = 1'b0; m_ptr = 0;
        tick();
        chk("post_rst_done", done_o, 0);
        new_cmd(3);
        pend = 4'b1000; drive(pend);
        tick(); w = pick(pend);
        xfer(w, 1, 0, $urandom, 0);
        pend = '0; drive(pend);
        tick();

        // Randomized batches against the reference model
        for (int b = 0; b < 8; b++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) if (pend[i]) new_cmd(i);
            drive(pend);
            ldm = '0;
            nx  = 0;
            while (pend != 0) begin
                elig = pend & ~ldm;
                if (elig == 0) begin
                    tick();
                    chk("gap_psel", psel, 0);
                    elig = pend;
                end
                tick(); w = pick(elig);
                xfer(w, $urandom_range(0, 4), 0, $urandom, 1'($urandom_range(0, 1)));
                ldm = 4'(1 << w);
                nx++;
                if (nx < 8 && $urandom_range(0, 1) == 1) new_cmd(w);
                else pend[w] = 1'b0;
                if (nx < 8 && $urandom_range(0, 2) == 0) begin
                    int k;
                    k = $urandom_range(0, N - 1);
                    if (!pend[k]) begin
                        new_cmd(k);
                        pend[k] = 1'b1;
                    end
                end
                drive(pend);
            end
            tick();
            chk("batch_idle_psel", psel, 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB4 master port between NUM_REQ on-chip requesters. It runs round-robin arbitration, sequences the APB SETUP/ACCESS protocol, and returns per-requester completion, read data and error status. It sits between the requester command ports and the APB interface (apb_if master side) exercised by the master VIP bench. A programmable wait-state timeout keeps a hung slave from blocking the bus.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; PSTRB width is DATA_W/8
- TIMEOUT, 16, ACCESS cycles allowed before a forced error; 0 disables the timeout
- pclk  in  1  APB clock; all logic is on the rising edge
- preset  in  1  reset, asynchronous, active-high
- req_i  in  NUM_REQ  per-requester request level
- addr_i  in  NUM_REQ×ADDR_W  per-requester address
- write_i  in  NUM_REQ  1 = write
- wdata_i  in  NUM_REQ×DATA_W  write data
- strb_i  in  NUM_REQ×DATA_W/8  write strobes
- done_o  out  NUM_REQ  one-cycle completion pulse to the owner
- rdata_o  out  DATA_W  read data, valid while any done_o bit is high
- err_o  out  1  error flag, valid while any done_o bit is high
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W
- pwdata  out  DATA_W
- pstrb  out  DATA_W/8
- pready, pslverr  in  1
- prdata  in  DATA_W

## Operation
- Requester protocol: assert req_i with a stable command. Hold it until done_o pulses. Drop req_i in the done cycle or issue the next command.
- States:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- IDLE → SETUP when any eligible req_i is high. The winner's command is registered into paddr/pwrite/pwdata/pstrb and the owner index is stored.
- Eligibility: a requester whose done_o bit is high in the current cycle is ineligible in that cycle.
- Round-robin: the pointer resets to 0. The winner is the first eligible requester at or after the pointer, with wrap-around. After a grant to k, pointer ← (k+1) mod NUM_REQ.
- SETUP → ACCESS unconditionally.
- ACCESS with pready=1 → IDLE, done_o[owner]=1 next cycle, rdata_o←prdata (reads), rdata_o←0 (writes), err_o←pslverr.
- ACCESS with pready=0: the wait counter increments. When it reaches TIMEOUT (TIMEOUT≠0) → IDLE, done_o[owner]=1, err_o=1, rdata_o=0.
- APB outputs hold stable from SETUP through the end of ACCESS. pstrb is forced to 0 for reads.
- req_i changes by non-owners during SETUP/ACCESS are ignored until the next IDLE. An owner dropping req_i mid-transfer does not abort it; done_o still pulses.

## Timing
- Reset: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, done_o=0, rdata_o=0, err_o=0, state IDLE, pointer 0, wait counter 0.
- Reset mid-transfer: psel/penable drop immediately (asynchronously), no done_o is issued, and the transfer is lost.
- Zero-wait transfer, with req sampled at edge 0:
  - SETUP during cycle 1.
  - ACCESS during cycle 2, pready sampled at edge 3.
  - done_o during cycle 3 (IDLE).
  - Next SETUP no earlier than cycle 4.
- Throughput: one transfer per 3 cycles plus wait states.
- Wait counter clears on entry to ACCESS. Timeout fires at the edge where TIMEOUT consecutive pready=0 ACCESS cycles have elapsed.
- pready=1 in the same cycle the counter hits TIMEOUT: pready wins (normal completion).
- done_o is never high for two requesters at once, and never for two consecutive cycles.

## Structure
- Package apb_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - default width localparams
  - function next_rr(ptr, mask) returning the winner index
- Sub-module apb_rr_arbiter: eligibility mask in; grant index and valid out; owns the pointer register and its update on grant.
- The top level holds the FSM, command registers, wait counter and response registers.

## Test plan
- Requester 0 writes 0xA5A5_0001 to 0x10, strb 0xF, pready tied 1 → psel in cycle 1, penable in cycle 2, done_o=4'b0001 in cycle 3, err_o=0.
- Requester 2 reads 0x20, slave inserts 3 wait states returning 0xDEAD_BEEF → done_o[2] one cycle after pready, rdata_o=0xDEAD_BEEF, pstrb=0 throughout.
- All four requesters assert simultaneously and keep requesting → grant order 0,1,2,3,0. Each holds paddr stable through its ACCESS.
- Slave returns pslverr=1 with pready on a write from requester 1 → err_o=1 with done_o[1].
- TIMEOUT=16, pready held 0 → after 16 ACCESS cycles done_o pulses, err_o=1, rdata_o=0, psel=0. The next requester is then served.
- preset asserted mid-ACCESS → psel/penable go 0 immediately, no done_o. After release, pointer=0 and a fresh requester-3 request completes normally.
